// File: rtl/mic_trig_pkg.sv
// Shared types and helpers for the microphone fire trigger: FSM state
// encoding, accumulator width and the sample magnitude function.
package mic_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_XFER  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_EVAL  = 3'd4
  } mic_state_e;

  // A window of 2^win_log2 magnitudes, each below 2^32, fits in 32+win_log2 bits.
  function automatic int unsigned acc_w(input int unsigned win_log2);
    return 32 + win_log2;
  endfunction

  // Unsigned magnitude; the most negative sample maps to 32'h8000_0000.
  function automatic logic [31:0] abs_mag(input logic [31:0] s);
    return s[31] ? (~s + 32'd1) : s;
  endfunction

endpackage

// File: rtl/mic_fire_trigger_if.sv
// Sample handshake between Audio_Controller (master) and the fire trigger (slave).
interface mic_fire_trigger_if;
  // audio_in_available / audio_out_allowed act as valid/ready from the FIFOs;
  // read_audio_in and write_audio_out pulse together for one cycle per sample,
  // with the loopback data held stable while they are high.
  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    output audio_in_available, audio_out_allowed,
    output left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, write_audio_out,
    input  left_channel_audio_out, right_channel_audio_out
  );

  modport slave (
    input  audio_in_available, audio_out_allowed,
    input  left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, write_audio_out,
    output left_channel_audio_out, right_channel_audio_out
  );
endinterface

// File: rtl/level_accumulator.sv
// Window accumulator: registers |left|, sums it once per sample and counts
// samples; last_o flags that the next accumulation completes the window.
module level_accumulator
  import mic_trig_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned ACC_W    = 42
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [31:0]      sample_i,
  input  logic             accum_i,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             last_o
);

  logic [31:0]         mag_q, mag_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] count_q, count_d;

  always_comb begin
    mag_d   = mag_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (load_i) begin
      mag_d = abs_mag(sample_i);
    end
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accum_i) begin
      acc_d   = acc_q + ACC_W'(mag_q);
      count_d = count_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = &count_q;

endmodule

// File: rtl/mic_fire_trigger.sv
// Audio sample sequencer with loopback; averages left-channel magnitude per
// window and derives fire/firing/level through hysteresis and refractory logic.
module mic_fire_trigger
  import mic_trig_pkg::*;
#(
  parameter int unsigned WIN_LOG2        = 10,
  parameter logic [31:0] HI_THRESH       = 32'h0400_0000,
  parameter logic [31:0] LO_THRESH       = 32'h0200_0000,
  parameter int unsigned HOLD_WINDOWS    = 2,
  parameter int unsigned REFRACT_WINDOWS = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  mic_fire_trigger_if.slave aud,
  output logic [7:0]        level,
  output logic              fire,
  output logic              firing,
  output logic              window_done,
  output mic_state_e        dbg_state_o
);

  localparam int unsigned ACC_W     = acc_w(WIN_LOG2);
  localparam logic [3:0]  HOLD_C    = 4'(HOLD_WINDOWS);
  localparam logic [3:0]  REFRACT_C = 4'(REFRACT_WINDOWS);

  mic_state_e       state_q, state_d;
  logic [31:0]      left_out_q, left_out_d;
  logic [31:0]      right_out_q, right_out_d;
  logic [7:0]       level_q, level_d;
  logic             fire_q, fire_d;
  logic             firing_q, firing_d;
  logic             wd_q, wd_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       refract_q, refract_d;
  logic             take;
  logic             acc_clear;
  logic             acc_en;
  logic             win_last;
  logic [ACC_W-1:0] acc;
  logic [31:0]      avg;

  assign take = (state_q == ST_WAIT) && enable &&
                aud.audio_in_available && aud.audio_out_allowed;
  assign acc_clear = (state_q == ST_IDLE) || (state_q == ST_EVAL);
  assign acc_en    = (state_q == ST_ACCUM);
  assign avg       = 32'(acc >> WIN_LOG2);

  level_accumulator #(
    .WIN_LOG2 (WIN_LOG2),
    .ACC_W    (ACC_W)
  ) u_acc (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .load_i   (take),
    .sample_i (aud.left_channel_audio_in),
    .accum_i  (acc_en),
    .clear_i  (acc_clear),
    .acc_o    (acc),
    .last_o   (win_last)
  );

  always_comb begin
    state_d     = state_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    level_d     = level_q;
    fire_d      = 1'b0;
    wd_d        = 1'b0;
    firing_d    = firing_q;
    hold_d      = hold_q;
    refract_d   = refract_q;

    case (state_q)
      ST_IDLE: begin
        // Leaving a run drops any trigger history but keeps the LED level.
        firing_d  = 1'b0;
        hold_d    = '0;
        refract_d = '0;
        if (enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (take) begin
          left_out_d  = aud.left_channel_audio_in;
          right_out_d = aud.right_channel_audio_in;
          state_d     = ST_XFER;
        end
      end
      ST_XFER:  state_d = ST_ACCUM;
      ST_ACCUM: state_d = win_last ? ST_EVAL : ST_WAIT;
      ST_EVAL: begin
        level_d = avg[31:24];
        wd_d    = 1'b1;
        if (avg >= HI_THRESH) begin
          hold_d = (hold_q >= HOLD_C) ? HOLD_C : hold_q + 4'd1;
        end else begin
          hold_d = '0;
        end
        if (refract_q != 4'd0) begin
          refract_d = refract_q - 4'd1;
        end else if (!firing_q && (hold_d == HOLD_C)) begin
          firing_d = 1'b1;
          fire_d   = 1'b1;
        end
        // Release only from an already-firing state, so it never collides with a new fire.
        if (firing_q && (avg < LO_THRESH)) begin
          firing_d  = 1'b0;
          refract_d = REFRACT_C;
          hold_d    = '0;
        end
        state_d = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      left_out_q  <= '0;
      right_out_q <= '0;
      level_q     <= '0;
      fire_q      <= 1'b0;
      wd_q        <= 1'b0;
      firing_q    <= 1'b0;
      hold_q      <= '0;
      refract_q   <= '0;
    end else begin
      state_q     <= state_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      level_q     <= level_d;
      fire_q      <= fire_d;
      wd_q        <= wd_d;
      firing_q    <= firing_d;
      hold_q      <= hold_d;
      refract_q   <= refract_d;
    end
  end

  assign aud.read_audio_in          = (state_q == ST_XFER);
  assign aud.write_audio_out        = (state_q == ST_XFER);
  assign aud.left_channel_audio_out  = left_out_q;
  assign aud.right_channel_audio_out = right_out_q;
  assign level       = level_q;
  assign fire        = fire_q;
  assign firing      = firing_q;
  assign window_done = wd_q;
  assign dbg_state_o = state_q;

endmodule
